// File: rtl/rd_burst_arbiter_if.sv
// Bus bundle between the read requesters, the SDRAM command port and the upsized read-data return.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface rd_burst_arbiter_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int WB_DW  = 32,
    parameter int MEM_DW = 16,
    parameter int BLEN_W = 4
);
    localparam int CLEN_W = BLEN_W + $clog2(WB_DW / MEM_DW);

    logic [NPORTS*AW-1:0]     req_adr_i;
    logic [NPORTS*BLEN_W-1:0] req_len_i;
    logic [NPORTS-1:0]        req_valid_i;
    logic [NPORTS-1:0]        req_ready_o;
    logic [AW-1:0]            cmd_adr_o;
    logic [CLEN_W-1:0]        cmd_len_o;
    logic                     cmd_valid_o;
    logic                     cmd_ready_i;
    logic [WB_DW-1:0]         rd_data_i;
    logic                     rd_valid_i;
    logic [WB_DW-1:0]         rsp_data_o;
    logic [NPORTS-1:0]        rsp_valid_o;
    logic                     rsp_last_o;
    logic [NPORTS-1:0]        grant_o;
    logic                     err_o;

    modport slave (
        input  req_adr_i, req_len_i, req_valid_i, cmd_ready_i, rd_data_i, rd_valid_i,
        output req_ready_o, cmd_adr_o, cmd_len_o, cmd_valid_o, rsp_data_o, rsp_valid_o,
               rsp_last_o, grant_o, err_o
    );

    modport master (
        output req_adr_i, req_len_i, req_valid_i, cmd_ready_i, rd_data_i, rd_valid_i,
        input  req_ready_o, cmd_adr_o, cmd_len_o, cmd_valid_o, rsp_data_o, rsp_valid_o,
               rsp_last_o, grant_o, err_o
    );
endinterface

// File: rtl/rd_burst_arbiter.sv
// Round-robin owner of the shared SDRAM read path: one burst command per grant, upsized words steered to the owner.
// Command one cycle after request; read data returned with zero latency; only cmd_ready_i can stall (read return has no backpressure).
module rd_burst_arbiter #(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int WB_DW  = 32,
    parameter int MEM_DW = 16,
    parameter int BLEN_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rd_burst_arbiter_if.slave   bus
);
    localparam int SCALE  = WB_DW / MEM_DW;
    localparam int SS     = $clog2(SCALE);
    localparam int CLEN_W = BLEN_W + SS;
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [AW-1:0] ADR_MASK = ~AW'((WB_DW / 8) - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;
    logic              pick_vld;
    logic [BLEN_W-1:0] len_q;
    logic [BLEN_W-1:0] cnt;
    logic [NPORTS-1:0] grant;
    logic [AW-1:0]     cmd_adr;
    logic [CLEN_W-1:0] cmd_len;
    logic              cmd_vld;
    logic              err;
    logic              hit;
    logic              last;
    logic [AW-1:0]     pick_adr;
    logic [BLEN_W-1:0] pick_len;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = PW'((int'(ptr) + k) % NPORTS);
            if (!pick_vld && bus.req_valid_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_adr = bus.req_adr_i[pick_idx*AW +: AW];
    assign pick_len = bus.req_len_i[pick_idx*BLEN_W +: BLEN_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PW'(NPORTS - 1);
            gnt_idx <= '0;
            grant   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            cmd_adr <= '0;
            cmd_len <= '0;
            cmd_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (bus.rd_valid_i && state != DATA)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_idx <= pick_idx;
                        grant   <= NPORTS'(1) << pick_idx;
                        len_q   <= pick_len;
                        cmd_adr <= pick_adr & ADR_MASK;
                        // (len+1)*SCALE-1 in beats; the extra SS bits absorb the maximum length.
                        cmd_len <= (CLEN_W'(pick_len) << SS) | CLEN_W'(SCALE - 1);
                        cmd_vld <= 1'b1;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (bus.cmd_ready_i) begin
                        cmd_vld <= 1'b0;
                        cnt     <= len_q;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bus.rd_valid_i) begin
                        if (cnt == '0) begin
                            grant <= '0;
                            ptr   <= gnt_idx;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hit  = (state == DATA) && bus.rd_valid_i;
    assign last = hit && (cnt == '0);

    assign bus.rsp_data_o  = hit ? bus.rd_data_i : '0;
    assign bus.rsp_valid_o = hit ? grant : '0;
    assign bus.rsp_last_o  = last;
    assign bus.req_ready_o = last ? grant : '0;
    assign bus.grant_o     = grant;
    assign bus.cmd_adr_o   = cmd_adr;
    assign bus.cmd_len_o   = cmd_len;
    assign bus.cmd_valid_o = cmd_vld;
    assign bus.err_o       = err;
endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Bench for rd_burst_arbiter: directed vector table, multi-cycle corner sequences and randomized bursts vs a round-robin model.
module tb_rd_burst_arbiter;
    localparam int NPORTS = 2;
    localparam int AW     = 32;
    localparam int WB_DW  = 32;
    localparam int MEM_DW = 16;
    localparam int BLEN_W = 4;
    localparam int SCALE  = WB_DW / MEM_DW;
    localparam logic [AW-1:0] AMASK = ~32'(WB_DW / 8 - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_burst_arbiter_if #(.NPORTS(NPORTS), .AW(AW), .WB_DW(WB_DW), .MEM_DW(MEM_DW), .BLEN_W(BLEN_W)) bus ();

    rd_burst_arbiter #(.NPORTS(NPORTS), .AW(AW), .WB_DW(WB_DW), .MEM_DW(MEM_DW), .BLEN_W(BLEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int ptr_m;
    bit err_m;
    logic [AW-1:0] adr_m [NPORTS];
    int            len_m [NPORTS];

    typedef struct {
        int            port;
        logic [AW-1:0] adr;
        int            len;
        int            rdy_dly;
        logic [AW-1:0] exp_adr;
        int            exp_len;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] adr, input int len);
        bus.req_adr_i[p*AW +: AW]         = adr;
        bus.req_len_i[p*BLEN_W +: BLEN_W] = BLEN_W'(len);
        bus.req_valid_i[p]                = 1'b1;
        adr_m[p] = adr;
        len_m[p] = len;
    endtask

    // Round-robin reference: first requester above the last owner, wrapping.
    function automatic int rr_pick(input logic [NPORTS-1:0] rv);
        for (int k = 1; k <= NPORTS; k++) begin
            if (rv[(ptr_m + k) % NPORTS]) return (ptr_m + k) % NPORTS;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},     64'(bus.grant_o), 0);
        check({tag, "_cmd_valid"}, 64'(bus.cmd_valid_o), 0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 0);
        check({tag, "_rsp_last"},  64'(bus.rsp_last_o), 0);
        check({tag, "_req_ready"}, 64'(bus.req_ready_o), 0);
        check({tag, "_rsp_data"},  64'(bus.rsp_data_o), 0);
        check({tag, "_err"},       64'(bus.err_o), 0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.req_valid_i = '0;
        bus.cmd_ready_i = 1'b0;
        bus.rd_valid_i  = 1'b0;
        bus.rd_data_i   = '0;
        #1;
        check_all_zero("rst");
        check("rst_cmd_adr", 64'(bus.cmd_adr_o), 0);
        check("rst_cmd_len", 64'(bus.cmd_len_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        ptr_m = NPORTS - 1;
        err_m = 1'b0;
    endtask

    // Caller has set up requests during an IDLE cycle; returns during the idle gap after completion.
    task automatic burst(input int p, input int len, input logic [AW-1:0] eadr, input int elen,
                         input int rdy_dly, input bit gaps, input bit drop_early, input bit drop_after);
        logic [NPORTS-1:0] mask;
        logic [WB_DW-1:0]  d;
        int                g;
        mask = NPORTS'(1) << p;
        tick();
        check("cmd_valid", 64'(bus.cmd_valid_o), 1);
        check("grant",     64'(bus.grant_o), 64'(mask));
        check("cmd_adr",   64'(bus.cmd_adr_o), 64'(eadr));
        check("cmd_len",   64'(bus.cmd_len_o), 64'(elen));
        if (drop_early) bus.req_valid_i[p] = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            check("hold_cmd_valid", 64'(bus.cmd_valid_o), 1);
            check("hold_cmd_adr",   64'(bus.cmd_adr_o), 64'(eadr));
            check("hold_cmd_len",   64'(bus.cmd_len_o), 64'(elen));
        end
        bus.cmd_ready_i = 1'b1;
        tick();
        bus.cmd_ready_i = 1'b0;
        check("cmd_taken", 64'(bus.cmd_valid_o), 0);
        check("grant_data", 64'(bus.grant_o), 64'(mask));
        for (int w = 0; w <= len; w++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                bus.rd_data_i = $urandom;
                #1;
                check("gap_rsp_valid", 64'(bus.rsp_valid_o), 0);
                check("gap_rsp_data",  64'(bus.rsp_data_o), 0);
                tick();
            end
            d = $urandom;
            bus.rd_valid_i = 1'b1;
            bus.rd_data_i  = d;
            #1;
            check("rsp_valid", 64'(bus.rsp_valid_o), 64'(mask));
            check("rsp_data",  64'(bus.rsp_data_o), 64'(d));
            check("rsp_last",  64'(bus.rsp_last_o), 64'(w == len));
            check("req_ready", 64'(bus.req_ready_o), (w == len) ? 64'(mask) : 64'(0));
            tick();
            bus.rd_valid_i = 1'b0;
            bus.rd_data_i  = '0;
        end
        ptr_m = p;
        if (drop_after) bus.req_valid_i[p] = 1'b0;
        #1;
        check("grant_clear", 64'(bus.grant_o), 0);
        check("gap_cmd_valid", 64'(bus.cmd_valid_o), 0);
        check("err", 64'(bus.err_o), 64'(err_m));
    endtask

    initial begin
        int alt [4];
        int p;
        logic [WB_DW-1:0] d;
        bus.req_adr_i   = '0;
        bus.req_len_i   = '0;
        bus.req_valid_i = '0;
        bus.cmd_ready_i = 1'b0;
        bus.rd_data_i   = '0;
        bus.rd_valid_i  = 1'b0;
        do_reset();

        tbl[0] = '{port: 0, adr: 32'h0000_1003, len: 3,  rdy_dly: 0, exp_adr: 32'h0000_1000, exp_len: 7};
        tbl[1] = '{port: 1, adr: 32'h0000_2002, len: 0,  rdy_dly: 5, exp_adr: 32'h0000_2000, exp_len: 1};
        tbl[2] = '{port: 0, adr: 32'hFFFF_FFFF, len: 15, rdy_dly: 1, exp_adr: 32'hFFFF_FFFC, exp_len: 31};
        tbl[3] = '{port: 1, adr: 32'h0000_0005, len: 7,  rdy_dly: 2, exp_adr: 32'h0000_0004, exp_len: 15};
        for (int i = 0; i < 4; i++) begin
            set_req(tbl[i].port, tbl[i].adr, tbl[i].len);
            burst(tbl[i].port, tbl[i].len, tbl[i].exp_adr, tbl[i].exp_len, tbl[i].rdy_dly, 1'b0, 1'b0, 1'b1);
        end

        // Both ports requesting continuously must alternate with one idle cycle in between.
        do_reset();
        alt = '{0, 1, 0, 1};
        set_req(0, 32'h0000_0100, 0);
        set_req(1, 32'h0000_0204, 0);
        for (int i = 0; i < 4; i++)
            burst(alt[i], 0, (alt[i] == 0) ? 32'h100 : 32'h204, SCALE - 1, 0, 1'b0, 1'b0, 1'b0);
        bus.req_valid_i = '0;

        // Spurious word in IDLE: dropped, sticky error survives a normal burst.
        bus.rd_valid_i = 1'b1;
        bus.rd_data_i  = 32'hDEAD_BEEF;
        #1;
        check("spur_rsp_valid", 64'(bus.rsp_valid_o), 0);
        check("spur_rsp_last",  64'(bus.rsp_last_o), 0);
        check("spur_req_ready", 64'(bus.req_ready_o), 0);
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_data_i  = '0;
        #1;
        check("spur_err", 64'(bus.err_o), 1);
        err_m = 1'b1;
        set_req(1, 32'h0000_3000, 2);
        burst(1, 2, 32'h0000_3000, 5, 0, 1'b1, 1'b0, 1'b1);

        // Reset mid-burst after two of four words.
        set_req(0, 32'h0000_4000, 3);
        tick();
        check("mr_cmd_valid", 64'(bus.cmd_valid_o), 1);
        bus.cmd_ready_i = 1'b1;
        tick();
        bus.cmd_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            bus.rd_valid_i = 1'b1;
            bus.rd_data_i  = d;
            #1;
            check("mr_rsp_valid", 64'(bus.rsp_valid_o), 1);
            check("mr_rsp_data",  64'(bus.rsp_data_o), 64'(d));
            tick();
        end
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        #1;
        check_all_zero("mr");
        tick();
        rst_n = 1'b1;
        ptr_m = NPORTS - 1;
        tick();
        bus.rd_valid_i = 1'b0;
        bus.rd_data_i  = '0;
        #1;
        check("mr_late_err", 64'(bus.err_o), 1);
        err_m = 1'b1;
        set_req(0, 32'h0000_5000, 1);
        set_req(1, 32'h0000_6000, 1);
        burst(0, 1, 32'h0000_5000, 3, 1, 1'b0, 1'b0, 1'b1);
        burst(1, 1, 32'h0000_6000, 3, 0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the round-robin model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            for (int q = 0; q < NPORTS; q++) begin
                if (!bus.req_valid_i[q] && $urandom_range(0, 1) == 1)
                    set_req(q, $urandom, int'($urandom_range(0, 15)));
            end
            if (bus.req_valid_i == '0) begin
                p = int'($urandom_range(0, NPORTS - 1));
                set_req(p, $urandom, int'($urandom_range(0, 15)));
            end
            p = rr_pick(bus.req_valid_i);
            burst(p, len_m[p], adr_m[p] & AMASK, (len_m[p] + 1) * SCALE - 1,
                  int'($urandom_range(0, 3)), 1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
